// File: rtl/tb4004_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tb4004_pkg
// Brief    : Shared opcode and FSM-state encodings for the TB4004 ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package tb4004_pkg;

  localparam logic [4:0] OP_CLB = 5'h00;
  localparam logic [4:0] OP_CLC = 5'h01;
  localparam logic [4:0] OP_IAC = 5'h02;
  localparam logic [4:0] OP_CMC = 5'h03;
  localparam logic [4:0] OP_CMA = 5'h04;
  localparam logic [4:0] OP_RAL = 5'h05;
  localparam logic [4:0] OP_RAR = 5'h06;
  localparam logic [4:0] OP_TCC = 5'h07;
  localparam logic [4:0] OP_DAC = 5'h08;
  localparam logic [4:0] OP_TCS = 5'h09;
  localparam logic [4:0] OP_STC = 5'h0A;
  localparam logic [4:0] OP_DAA = 5'h0B;
  localparam logic [4:0] OP_KBP = 5'h0C;
  localparam logic [4:0] OP_ADD = 5'h10;
  localparam logic [4:0] OP_SUB = 5'h11;
  localparam logic [4:0] OP_LD  = 5'h12;
  localparam logic [4:0] OP_XCH = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ADD/SUB/LD stage the scratchpad register into Temp; every other op stages ACC.
  function automatic logic uses_reg_operand(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational 4-bit accumulator ALU with carry; DAA/KBP present
//            only when TB4004_DAA_KBP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import tb4004_pkg::*;
(
  input  logic [4:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] result,
  output logic       cout,
  output logic       acc_wr,
  output logic       c_wr
);

  logic [4:0] w_sum;

  always_comb begin
    result = a;
    cout   = cin;
    acc_wr = 1'b0;
    c_wr   = 1'b0;
    w_sum  = 5'd0;
    case (op)
      OP_CLB: begin result = 4'd0; cout = 1'b0; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_CLC: begin cout = 1'b0; c_wr = 1'b1; end
      OP_IAC: begin
        w_sum  = {1'b0, a} + 5'd1;
        result = w_sum[3:0]; cout = w_sum[4]; acc_wr = 1'b1; c_wr = 1'b1;
      end
      OP_CMC: begin cout = ~cin; c_wr = 1'b1; end
      OP_CMA: begin result = ~a; acc_wr = 1'b1; end
      OP_RAL: begin result = {a[2:0], cin}; cout = a[3]; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_RAR: begin result = {cin, a[3:1]}; cout = a[0]; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_TCC: begin result = {3'b000, cin}; cout = 1'b0; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_DAC: begin
        w_sum  = {1'b0, a} + 5'h0F;
        result = w_sum[3:0]; cout = w_sum[4]; acc_wr = 1'b1; c_wr = 1'b1;
      end
      OP_TCS: begin
        result = cin ? 4'd10 : 4'd9; cout = 1'b0; acc_wr = 1'b1; c_wr = 1'b1;
      end
      OP_STC: begin cout = 1'b1; c_wr = 1'b1; end
`ifdef TB4004_DAA_KBP_EN
      OP_DAA: begin
        acc_wr = 1'b1;
        c_wr   = 1'b1;
        if ((a > 4'd9) || cin) begin
          w_sum  = {1'b0, a} + 5'd6;
          result = w_sum[3:0];
          cout   = cin | w_sum[4];
        end
      end
      OP_KBP: begin
        acc_wr = 1'b1;
        case (a)
          4'd0:    result = 4'd0;
          4'd1:    result = 4'd1;
          4'd2:    result = 4'd2;
          4'd4:    result = 4'd3;
          4'd8:    result = 4'd4;
          default: result = 4'hF;
        endcase
      end
`endif
      OP_ADD: begin
        w_sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        result = w_sum[3:0]; cout = w_sum[4]; acc_wr = 1'b1; c_wr = 1'b1;
      end
      // Carry acts as not-borrow: a set carry subtracts nothing extra.
      OP_SUB: begin
        w_sum  = {1'b0, a} + {1'b0, ~b} + {4'b0000, cin};
        result = w_sum[3:0]; cout = w_sum[4]; acc_wr = 1'b1; c_wr = 1'b1;
      end
      OP_LD:  begin result = b; acc_wr = 1'b1; end
      OP_XCH: begin result = b; acc_wr = 1'b1; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Four-state LOAD/EXEC/DONE sequencer driving the ACC/Temp write bus
//            and owning the carry flag. Macro: TB4004_DAA_KBP_EN (DAA/KBP ops).
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import tb4004_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] op,
  input  logic [3:0] reg_in,
  input  logic [3:0] acc_in,
  input  logic [3:0] temp_in,
  output logic [3:0] alu_result,
  output logic       acc_we,
  output logic       temp_we,
  output logic       reg_we,
  output logic [3:0] reg_wdata,
  output logic       carry,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_op;
  logic [3:0] r_reg;
  logic       r_carry;

  logic [3:0] w_b;
  logic [3:0] w_result;
  logic       w_cout;
  logic       w_acc_wr;
  logic       w_c_wr;

  // XCH loads ACC from the captured register; all other ops see Temp on b.
  assign w_b = (r_op == OP_XCH) ? r_reg : temp_in;

  alu_core u_alu_core (
    .op     (r_op),
    .a      (acc_in),
    .b      (w_b),
    .cin    (r_carry),
    .result (w_result),
    .cout   (w_cout),
    .acc_wr (w_acc_wr),
    .c_wr   (w_c_wr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= 5'd0;
      r_reg   <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && start) begin
        r_op  <= op;
        r_reg <= reg_in;
      end
      if ((r_state == ST_EXEC) && w_c_wr) begin
        r_carry <= w_cout;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    alu_result = 4'd0;
    acc_we     = 1'b0;
    temp_we    = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = 4'd0;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: begin
        w_next     = ST_EXEC;
        temp_we    = 1'b1;
        alu_result = uses_reg_operand(r_op) ? r_reg : acc_in;
      end
      ST_EXEC: begin
        w_next     = ST_DONE;
        acc_we     = w_acc_wr;
        alu_result = w_result;
        if (r_op == OP_XCH) begin
          reg_we    = 1'b1;
          reg_wdata = temp_in;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
        done   = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy  = (r_state != ST_IDLE);
  assign carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Self-checking bench for alu_sequencer with an ACC/Temp register
//            model and an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
  import tb4004_pkg::*;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [4:0] op     = 5'd0;
  logic [3:0] reg_in = 4'd0;
  logic [3:0] acc_in, temp_in;
  logic [3:0] alu_result, reg_wdata;
  logic       acc_we, temp_we, reg_we, carry, busy, done;

  logic [3:0] acc_q   = 4'd0;
  logic [3:0] temp_q  = 4'd0;
  bit         c_model = 1'b0;
  int         total   = 0;
  int         bad     = 0;

  assign acc_in  = acc_q;
  assign temp_in = temp_q;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .reg_in     (reg_in),
    .acc_in     (acc_in),
    .temp_in    (temp_in),
    .alu_result (alu_result),
    .acc_we     (acc_we),
    .temp_we    (temp_we),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .carry      (carry),
    .busy       (busy),
    .done       (done)
  );

  // Reference: new ACC / carry from the instruction-set rules in plain arithmetic.
  function automatic void ref_exec(input logic [4:0] o, input int acc, input int tmp,
                                   input int c, input int rg, output int nacc,
                                   output int nc, output bit awr, output bit rwr);
    int s;
    nacc = acc; nc = c; awr = 0; rwr = 0; s = 0;
    case (o)
      5'h00: begin nacc = 0; nc = 0; awr = 1; end
      5'h01: nc = 0;
      5'h02: begin s = acc + 1; nacc = s % 16; nc = s / 16; awr = 1; end
      5'h03: nc = 1 - c;
      5'h04: begin nacc = 15 - acc; awr = 1; end
      5'h05: begin s = acc * 2 + c; nacc = s % 16; nc = s / 16; awr = 1; end
      5'h06: begin nacc = c * 8 + acc / 2; nc = acc % 2; awr = 1; end
      5'h07: begin nacc = c; nc = 0; awr = 1; end
      5'h08: begin s = acc + 15; nacc = s % 16; nc = s / 16; awr = 1; end
      5'h09: begin nacc = (c == 1) ? 10 : 9; nc = 0; awr = 1; end
      5'h0A: nc = 1;
`ifdef TB4004_DAA_KBP_EN
      5'h0B: begin
        awr = 1;
        if (acc > 9 || c == 1) begin
          s = acc + 6; nacc = s % 16;
          if (s > 15) nc = 1;
        end
      end
      5'h0C: begin
        awr = 1;
        case (acc)
          0: nacc = 0;
          1: nacc = 1;
          2: nacc = 2;
          4: nacc = 3;
          8: nacc = 4;
          default: nacc = 15;
        endcase
      end
`endif
      5'h10: begin s = acc + tmp + c; nacc = s % 16; nc = s / 16; awr = 1; end
      5'h11: begin s = acc - tmp - (1 - c) + 16; nacc = s % 16; nc = s / 16; awr = 1; end
      5'h12: begin nacc = tmp; awr = 1; end
      5'h13: begin nacc = rg; awr = 1; rwr = 1; end
      default: ;
    endcase
  endfunction

  // Runs one full op starting mid-cycle; leaves the bench mid-cycle in IDLE.
  task automatic run_op(input logic [4:0] o, input logic [3:0] r);
    logic [3:0] opnd, t_d, a_d, old_acc;
    int         nacc, nc;
    bit         awr, rwr, t_w, a_w;
    start = 1'b1; op = o; reg_in = r;
    @(posedge clk); #1;
    start = 1'b0; op = 5'($urandom); reg_in = 4'($urandom);
    #1;
    opnd = (o == 5'h10 || o == 5'h11 || o == 5'h12) ? r : acc_q;
    total++;
    if (busy !== 1'b1 || temp_we !== 1'b1 || acc_we !== 1'b0 || reg_we !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL load_strobes op=%h got busy=%b temp_we=%b acc_we=%b reg_we=%b done=%b want 1 1 0 0 0",
               o, busy, temp_we, acc_we, reg_we, done);
    end
    total++;
    if (alu_result !== opnd) begin
      bad++;
      $display("FAIL load_data op=%h got %h want %h", o, alu_result, opnd);
    end
    t_w = temp_we; t_d = alu_result;
    @(posedge clk); #1;
    if (t_w) temp_q = t_d;
    #1;
    old_acc = acc_q;
    ref_exec(o, int'(acc_q), int'(temp_q), int'(c_model), int'(r), nacc, nc, awr, rwr);
    total++;
    if (acc_we !== awr || reg_we !== rwr || temp_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL exec_strobes op=%h got acc_we=%b reg_we=%b temp_we=%b done=%b busy=%b want %b %b 0 0 1",
               o, acc_we, reg_we, temp_we, done, busy, awr, rwr);
    end
    if (awr) begin
      total++;
      if (alu_result !== 4'(nacc)) begin
        bad++;
        $display("FAIL exec_result op=%h got %h want %h", o, alu_result, 4'(nacc));
      end
    end
    if (rwr) begin
      total++;
      if (reg_wdata !== old_acc) begin
        bad++;
        $display("FAIL xch_wdata got %h want %h", reg_wdata, old_acc);
      end
    end
    a_w = acc_we; a_d = alu_result;
    @(posedge clk); #1;
    if (a_w) acc_q = a_d;
    c_model = (nc != 0);
    #1;
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || acc_we !== 1'b0 || temp_we !== 1'b0 || reg_we !== 1'b0) begin
      bad++;
      $display("FAIL done_strobes op=%h got done=%b busy=%b acc_we=%b temp_we=%b reg_we=%b want 1 1 0 0 0",
               o, done, busy, acc_we, temp_we, reg_we);
    end
    total++;
    if (carry !== c_model || acc_q !== 4'(nacc)) begin
      bad++;
      $display("FAIL result_state op=%h got acc=%h c=%b want acc=%h c=%b", o, acc_q, carry, 4'(nacc), c_model);
    end
    @(posedge clk); #2;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_result !== 4'd0 || reg_wdata !== 4'd0 || temp_we !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs op=%h got busy=%b done=%b result=%h wdata=%h temp_we=%b",
               o, busy, done, alu_result, reg_wdata, temp_we);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0 || acc_we !== 1'b0 || temp_we !== 1'b0 ||
        reg_we !== 1'b0 || alu_result !== 4'd0 || reg_wdata !== 4'd0) begin
      bad++;
      $display("FAIL reset_values got busy=%b done=%b carry=%b acc_we=%b temp_we=%b reg_we=%b result=%h wdata=%h",
               busy, done, carry, acc_we, temp_we, reg_we, alu_result, reg_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_add();
    run_op(OP_STC, 4'd0);
    acc_q = 4'd9;
    run_op(OP_ADD, 4'd8);
    total++;
    if (acc_q !== 4'd2 || carry !== 1'b1) begin
      bad++;
      $display("FAIL add_9_8_c1 got acc=%h c=%b want acc=2 c=1", acc_q, carry);
    end
  endtask

  task automatic test_sub();
    run_op(OP_STC, 4'd0);
    acc_q = 4'd5;
    run_op(OP_SUB, 4'd3);
    total++;
    if (acc_q !== 4'd2 || carry !== 1'b1) begin
      bad++;
      $display("FAIL sub_no_borrow got acc=%h c=%b want acc=2 c=1", acc_q, carry);
    end
    run_op(OP_SUB, 4'd3);
    total++;
    if (acc_q !== 4'hF || carry !== 1'b0) begin
      bad++;
      $display("FAIL sub_borrow got acc=%h c=%b want acc=f c=0", acc_q, carry);
    end
  endtask

  task automatic test_xch();
    acc_q = 4'hA;
    run_op(OP_XCH, 4'h3);
    total++;
    if (acc_q !== 4'h3 || temp_q !== 4'hA) begin
      bad++;
      $display("FAIL xch_swap got acc=%h temp=%h want acc=3 temp=a", acc_q, temp_q);
    end
  endtask

  task automatic test_rot_daa();
    run_op(OP_STC, 4'd0);
    acc_q = 4'h9;
    run_op(OP_RAL, 4'd0);
    total++;
    if (acc_q !== 4'h3 || carry !== 1'b1) begin
      bad++;
      $display("FAIL ral got acc=%h c=%b want acc=3 c=1", acc_q, carry);
    end
    run_op(OP_RAR, 4'd0);
    total++;
    if (acc_q !== 4'h9 || carry !== 1'b1) begin
      bad++;
      $display("FAIL rar got acc=%h c=%b want acc=9 c=1", acc_q, carry);
    end
    run_op(OP_CLC, 4'd0);
    acc_q = 4'hC;
    run_op(OP_DAA, 4'd0);
`ifdef TB4004_DAA_KBP_EN
    total++;
    if (acc_q !== 4'h2 || carry !== 1'b1) begin
      bad++;
      $display("FAIL daa got acc=%h c=%b want acc=2 c=1", acc_q, carry);
    end
`else
    total++;
    if (acc_q !== 4'hC || carry !== 1'b0) begin
      bad++;
      $display("FAIL daa_disabled got acc=%h c=%b want acc=c c=0", acc_q, carry);
    end
`endif
  endtask

  task automatic test_reset_mid();
    run_op(OP_STC, 4'd0);
    acc_q = 4'd7;
    start = 1'b1; op = OP_ADD; reg_in = 4'd4;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    c_model = 1'b0;
    total++;
    if (acc_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || carry !== 1'b0 || reg_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_abort got acc_we=%b done=%b busy=%b carry=%b reg_we=%b want all 0",
               acc_we, done, busy, carry, reg_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || carry !== 1'b0 || acc_q !== 4'd7) begin
      bad++;
      $display("FAIL reset_mid_after got busy=%b done=%b carry=%b acc=%h want 0 0 0 7", busy, done, carry, acc_q);
    end
    #1;
  endtask

  task automatic test_back_to_back();
    int ndone, first_i, second_i;
    ndone = 0; first_i = -1; second_i = -1;
    run_op(OP_CLC, 4'd0);
    start = 1'b1; op = OP_CMC;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i == 0) op = OP_CLC;
      if (i == 2) op = OP_CMC;
      if (i == 7) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first_i < 0) first_i = i; else second_i = i;
      end
      if (i == 2) begin
        total++;
        if (carry !== 1'b1) begin
          bad++;
          $display("FAIL b2b_first_cmc got c=%b want 1", carry);
        end
      end
    end
    #1;
    c_model = 1'b0;
    total++;
    if (ndone != 2 || second_i - first_i != 4) begin
      bad++;
      $display("FAIL b2b_done_count got count=%0d spacing=%0d want count=2 spacing=4",
               ndone, second_i - first_i);
    end
    total++;
    if (carry !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final got c=%b busy=%b want c=0 busy=0", carry, busy);
    end
  endtask

  task automatic test_random();
    logic [4:0] ops [21];
    ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
            5'h0B, 5'h0C, 5'h0D, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h1F, 5'h0E};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) acc_q = 4'($urandom);
      run_op(ops[$urandom_range(0, 20)], 4'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_xch();
    test_rot_daa();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
